// File: rtl/fwd_track_pkg.sv
// Shared constants for the Y86 operand-forwarding unit: widths, the "no register"
// id and the stage indices used by the in-flight destination tracker.
package fwd_track_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // Register id that means "no register"; never matches as a forward source.
  localparam int RNONE_ID = 'hF;

  // Tracked stage indices after decode.
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  localparam int NSTAGE_DEF = STG_W + 1;

endpackage

// File: rtl/fwd_sel.sv
// Combinational priority selector for one decode source operand: picks the
// youngest matching stage result, falling back to the regfile value.
module fwd_sel
  import fwd_track_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int DATA_W = WORD_W,
  parameter int REG_W  = BYTE_W,
  parameter logic [REG_W-1:0] RNONE = REG_W'(RNONE_ID)
) (
  input  logic [REG_W-1:0]         src,
  input  logic [DATA_W-1:0]        rval,
  input  logic [NSTAGE*REG_W-1:0]  dst_e,
  input  logic [NSTAGE*REG_W-1:0]  dst_m,
  input  logic [NSTAGE*DATA_W-1:0] val_e,
  input  logic [NSTAGE*DATA_W-1:0] val_m,
  input  logic                     e_kill,
  output logic [DATA_W-1:0]        val,
  output logic                     hit
);

  // E.dstM is a load still in flight, so its slot never forwards.
  logic unused_e_m;
  assign unused_e_m = ^{dst_m[REG_W-1:0], val_m[DATA_W-1:0]};

  // Walk oldest to youngest so that each later match overrides an older one;
  // within a stage dstE is tried before dstM, leaving dstM with priority.
  always_comb begin
    val = rval;
    hit = 1'b0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (dst_e[k*REG_W +: REG_W] == src) begin
        val = val_e[k*DATA_W +: DATA_W];
        hit = 1'b1;
      end
      if (dst_m[k*REG_W +: REG_W] == src) begin
        val = val_m[k*DATA_W +: DATA_W];
        hit = 1'b1;
      end
    end
    if (!e_kill && dst_e[STG_E*REG_W +: REG_W] == src) begin
      val = val_e[STG_E*DATA_W +: DATA_W];
      hit = 1'b1;
    end
    if (src == RNONE) begin
      val = rval;
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/fwd_track.sv
// Operand-forwarding unit for the Y86 pipeline: tracks in-flight destinations,
// forwards operands to decode, raises load/use stalls and counts them.
module fwd_track
  import fwd_track_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int DATA_W = WORD_W,
  parameter int REG_W  = BYTE_W,
  parameter logic [REG_W-1:0] RNONE = REG_W'(RNONE_ID),
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold_i,
  input  logic                     id_valid_i,
  input  logic [REG_W-1:0]         id_dstE_i,
  input  logic [REG_W-1:0]         id_dstM_i,
  input  logic                     flush_i,
  input  logic                     e_kill_i,
  input  logic [NSRC*REG_W-1:0]    src_i,
  input  logic [NSRC*DATA_W-1:0]   rval_i,
  input  logic [NSTAGE*DATA_W-1:0] valE_i,
  input  logic [NSTAGE*DATA_W-1:0] valM_i,
  output logic [NSRC*DATA_W-1:0]   val_o,
  output logic [NSRC-1:0]          hit_o,
  output logic                     load_use_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  logic [REG_W-1:0]        trk_e [NSTAGE];
  logic [REG_W-1:0]        trk_m [NSTAGE];
  logic [NSTAGE*REG_W-1:0] dst_e_flat;
  logic [NSTAGE*REG_W-1:0] dst_m_flat;
  logic                    issue;

  always_comb begin
    dst_e_flat = '0;
    dst_m_flat = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      dst_e_flat[k*REG_W +: REG_W] = trk_e[k];
      dst_m_flat[k*REG_W +: REG_W] = trk_m[k];
    end
  end

  // A source waiting on the load currently in E must stall one cycle.
  always_comb begin
    load_use_o = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      if (src_i[j*REG_W +: REG_W] != RNONE &&
          src_i[j*REG_W +: REG_W] == trk_m[STG_E])
        load_use_o = 1'b1;
    end
  end

  assign issue = id_valid_i && !flush_i && !load_use_o;

  // Tracker shifts one stage per cycle; the oldest entry drops off as it retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        trk_e[k] <= RNONE;
        trk_m[k] <= RNONE;
      end
    end else if (!hold_i) begin
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        trk_e[k] <= trk_e[k-1];
        trk_m[k] <= trk_m[k-1];
      end
      if (e_kill_i)
        trk_e[STG_M] <= RNONE;
      trk_e[STG_E] <= issue ? id_dstE_i : RNONE;
      trk_m[STG_E] <= issue ? id_dstM_i : RNONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (!hold_i && load_use_o && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

  for (genvar j = 0; j < NSRC; j++) begin : g_sel
    fwd_sel #(
      .NSTAGE(NSTAGE),
      .DATA_W(DATA_W),
      .REG_W (REG_W),
      .RNONE (RNONE)
    ) u_sel (
      .src   (src_i[j*REG_W +: REG_W]),
      .rval  (rval_i[j*DATA_W +: DATA_W]),
      .dst_e (dst_e_flat),
      .dst_m (dst_m_flat),
      .val_e (valE_i),
      .val_m (valM_i),
      .e_kill(e_kill_i),
      .val   (val_o[j*DATA_W +: DATA_W]),
      .hit   (hit_o[j])
    );
  end

endmodule
